// File: rtl/lock_sequencer.sv
// Password-lock sequencer: turns match/failure results into a timed unlock
// window, a timed alarm and a datapath clear handshake, and gates key strobes.
module lock_sequencer #(
  parameter int unsigned UNLOCK_CYCLES = 5,
  parameter int unsigned ALARM_CYCLES  = 10,
  parameter int unsigned FAIL_LIMIT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyboard_en_in,
  input  logic [3:0] keyboard_num_in,
  input  logic       lock_button,
  input  logic       match,
  input  logic [1:0] failure_times,
  output logic       keyboard_en_out,
  output logic [3:0] keyboard_num_out,
  output logic       unlock,
  output logic       alarm,
  output logic       datapath_clear,
  output logic [1:0] lock_state,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    ALARM   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] UNLOCK_LOAD = 8'(UNLOCK_CYCLES);
  localparam logic [7:0] ALARM_LOAD  = 8'(ALARM_CYCLES);
  localparam logic [1:0] FAIL_LIM    = 2'(FAIL_LIMIT);

  state_t     state;
  logic [7:0] timer;
  logic       match_q, button_q, fail_q;

  logic fail_hit, match_rise, button_rise, fail_rise;

  assign fail_hit    = (failure_times >= FAIL_LIM);
  assign match_rise  = match & ~match_q;
  assign button_rise = lock_button & ~button_q;
  assign fail_rise   = fail_hit & ~fail_q;

  assign keyboard_en_out  = keyboard_en_in & (state == LOCKED);
  assign keyboard_num_out = keyboard_num_in;
  assign lock_state       = state;
  assign remaining        = timer;

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the values from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LOCKED;
      timer          <= 8'd0;
      unlock         <= 1'b0;
      alarm          <= 1'b0;
      datapath_clear <= 1'b0;
      // Previous values start high so a level held across reset is not an edge.
      match_q        <= 1'b1;
      button_q       <= 1'b1;
      fail_q         <= 1'b1;
    end else begin
      match_q  <= match;
      button_q <= lock_button;
      fail_q   <= fail_hit;

      unique case (state)
        LOCKED: begin
          if (fail_rise) begin
            state <= ALARM;
            timer <= ALARM_LOAD;
            alarm <= 1'b1;
          end else if (match_rise) begin
            state  <= OPEN;
            timer  <= UNLOCK_LOAD;
            unlock <= 1'b1;
          end
        end
        OPEN: begin
          if (timer == 8'd1 || button_rise) begin
            state  <= LOCKED;
            timer  <= 8'd0;
            unlock <= 1'b0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ALARM: begin
          if (timer == 8'd1) begin
            state          <= HOLDOFF;
            timer          <= 8'd0;
            alarm          <= 1'b0;
            datapath_clear <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        HOLDOFF: begin
          // Wait for the datapath to report a cleared failure count.
          if (!fail_hit && !match) begin
            state          <= LOCKED;
            datapath_clear <= 1'b0;
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus random
// stimulus compared against a cycle-count reference model.
module tb_lock_sequencer;

  localparam int UNLOCK_N = 5;
  localparam int ALARM_N  = 10;
  localparam int LIMIT    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       keyboard_en_in;
  logic [3:0] keyboard_num_in;
  logic       lock_button;
  logic       match;
  logic [1:0] failure_times;
  logic       keyboard_en_out;
  logic [3:0] keyboard_num_out;
  logic       unlock;
  logic       alarm;
  logic       datapath_clear;
  logic [1:0] lock_state;
  logic [7:0] remaining;

  lock_sequencer #(
    .UNLOCK_CYCLES(UNLOCK_N),
    .ALARM_CYCLES (ALARM_N),
    .FAIL_LIMIT   (LIMIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .keyboard_en_in  (keyboard_en_in),
    .keyboard_num_in (keyboard_num_in),
    .lock_button     (lock_button),
    .match           (match),
    .failure_times   (failure_times),
    .keyboard_en_out (keyboard_en_out),
    .keyboard_num_out(keyboard_num_out),
    .unlock          (unlock),
    .alarm           (alarm),
    .datapath_clear  (datapath_clear),
    .lock_state      (lock_state),
    .remaining       (remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: remaining cycles of each window plus a holdoff flag.
  int open_left, alarm_left;
  bit holdoff;
  bit m_prev, b_prev, f_prev;

  function automatic int exp_state();
    if (holdoff)             return 3;
    else if (alarm_left > 0) return 2;
    else if (open_left > 0)  return 1;
    else                     return 0;
  endfunction

  task automatic model_reset();
    open_left = 0; alarm_left = 0; holdoff = 0;
    m_prev = 1; b_prev = 1; f_prev = 1;
  endtask

  task automatic model_step(input bit m, input bit b, input int ft);
    bit fh, mr, br, fr;
    fh = (ft >= LIMIT);
    mr = m & !m_prev;
    br = b & !b_prev;
    fr = fh & !f_prev;
    if (holdoff) begin
      if (!fh && !m) holdoff = 0;
    end else if (alarm_left > 0) begin
      alarm_left--;
      if (alarm_left == 0) holdoff = 1;
    end else if (open_left > 0) begin
      open_left = br ? 0 : open_left - 1;
    end else if (fr) begin
      alarm_left = ALARM_N;
    end else if (mr) begin
      open_left = UNLOCK_N;
    end
    m_prev = m; b_prev = b; f_prev = fh;
  endtask

  task automatic check_outputs();
    check("lock_state",     int'(lock_state),     exp_state());
    check("remaining",      int'(remaining),      open_left + alarm_left);
    check("unlock",         int'(unlock),         int'(exp_state() == 1));
    check("alarm",          int'(alarm),          int'(exp_state() == 2));
    check("datapath_clear", int'(datapath_clear), int'(exp_state() == 3));
  endtask

  // One clock: check at negedge, drive new inputs, check the gated strobe,
  // then advance the model on the rising edge that samples them.
  task automatic cycle(input bit m, input bit b, input int ft, input bit ke, input int kn);
    @(negedge clk);
    check_outputs();
    match = m; lock_button = b; failure_times = 2'(ft);
    keyboard_en_in = ke; keyboard_num_in = 4'(kn);
    #1;
    check("keyboard_en_out",  int'(keyboard_en_out),  int'(ke && exp_state() == 0));
    check("keyboard_num_out", int'(keyboard_num_out), kn);
    @(posedge clk);
    model_step(m, b, ft);
  endtask

  // Asynchronous reset in mid-cycle, inputs left as they are.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_state",     int'(lock_state),     0);
    check("rst_remaining", int'(remaining),      0);
    check("rst_unlock",    int'(unlock),         0);
    check("rst_alarm",     int'(alarm),          0);
    check("rst_clear",     int'(datapath_clear), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    match = 0; lock_button = 0; failure_times = 0;
    keyboard_en_in = 0; keyboard_num_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_state",     int'(lock_state), 0);
    check("por_remaining", int'(remaining),  0);
    check("por_unlock",    int'(unlock),     0);
    reset = 1'b0;

    // Unlock window with key presses inside it.
    repeat (3) cycle(0, 0, 0, 1, 4'h7);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, i[0], i);
    cycle(0, 0, 0, 1, 9);

    // Alarm, holdoff, then clear two cycles later.
    cycle(0, 0, 3, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 3, 1, 1);
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Simultaneous match and failure limit: alarm wins.
    cycle(1, 0, 3, 0, 0);
    for (int i = 0; i < 11; i++) cycle(1, 0, 3, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Early relock on the second open cycle, button held afterwards.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (8) cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // Reset in the 4th alarm cycle with match held high.
    cycle(1, 0, 3, 0, 0);
    repeat (3) cycle(1, 0, 3, 0, 0);
    async_reset();
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);

    // Random traffic with occasional asynchronous resets.
    begin
      bit m, b, ke;
      int ft;
      m = 0; b = 0; ft = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(4) == 0)  m  = ~m;
        if ($urandom_range(5) == 0)  b  = ~b;
        if ($urandom_range(7) == 0)  ft = int'($urandom_range(3));
        ke = ($urandom_range(1) == 1);
        if ($urandom_range(399) == 0) async_reset();
        else cycle(m, b, ft, ke, int'($urandom_range(15)));
      end
    end

    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
